// File: rtl/seq_pkg.sv
// Shared types and constants for the playlist sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        LOAD    = 2'd1,
        PLAY    = 2'd2,
        GAP     = 2'd3
    } seq_state_t;

    // repeat_mode encodings; 2'b11 falls through to repeat-all
    localparam logic [1:0] REP_NONE = 2'b00;
    localparam logic [1:0] REP_ALL  = 2'b01;
    localparam logic [1:0] REP_ONE  = 2'b10;

    // x^8+x^6+x^5+x^4+1, shift-left Fibonacci form: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/seq_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the shuffle source.
module seq_lfsr8
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] lfsr
);

    // shift left, feedback is the parity of the tapped bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end

endmodule

// File: rtl/playlist_sequencer.sv
// Playlist sequencer: track select, playback gating, restart pulse on
// every track change, auto-advance with silent gap and repeat modes.
// Optional shuffle is built only when SEQ_SHUFFLE_EN is defined.
module playlist_sequencer
    import seq_pkg::*;
#(
    parameter int  NUM_SONGS  = 4,
    parameter int  GAP_CYCLES = 50_000_000,
    localparam int SEL_W      = $clog2(NUM_SONGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             next,
    input  logic             prev,
    input  logic             song_finished,
    input  logic [1:0]       repeat_mode,
    input  logic             shuffle,
    output logic [SEL_W-1:0] song_sel,
    output logic             play_en,
    output logic             restart,
    output logic             at_end
);

    localparam logic [SEL_W-1:0] LAST     = SEL_W'(NUM_SONGS - 1);
    localparam logic [31:0]      GAP_LOAD = 32'(GAP_CYCLES - 1);

    function automatic logic [SEL_W-1:0] inc_idx(input logic [SEL_W-1:0] i);
        return (i == LAST) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [SEL_W-1:0] dec_idx(input logic [SEL_W-1:0] i);
        return (i == '0) ? LAST : i - 1'b1;
    endfunction

    seq_state_t       state, nxt_state;
    logic [SEL_W-1:0] nxt_sel, fwd_sel, auto_sel;
    logic [31:0]      gap_cnt, nxt_gap;
    logic             pend_end, nxt_pend, nxt_at_end, auto_end;
    logic             finished_d, fin_edge;

    assign fin_edge = song_finished & ~finished_d;
    assign play_en  = (state == PLAY);
    assign restart  = (state == LOAD);

`ifdef SEQ_SHUFFLE_EN
    localparam int PC_W = $clog2(NUM_SONGS + 1);

    logic [7:0]      lfsr;
    logic [PC_W-1:0] played, nxt_played;

    seq_lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr)
    );

    // random pick that never lands on the current track
    function automatic logic [SEL_W-1:0] shuf_pick(input logic [7:0] r,
                                                   input logic [SEL_W-1:0] cur);
        logic [SEL_W-1:0] p;
        p = SEL_W'(32'(r) % NUM_SONGS);
        return (p == cur) ? inc_idx(cur) : p;
    endfunction
`else
    logic unused_shuffle;
    assign unused_shuffle = shuffle;
`endif

    // forward-skip target and auto-advance target for the current track
    always_comb begin
        fwd_sel  = inc_idx(song_sel);
        auto_sel = fwd_sel;
        auto_end = 1'b0;
`ifdef SEQ_SHUFFLE_EN
        if (shuffle) fwd_sel = shuf_pick(lfsr, song_sel);
        auto_sel = fwd_sel;
`endif
        case (repeat_mode)
            REP_ONE: auto_sel = song_sel;
            REP_NONE: begin
`ifdef SEQ_SHUFFLE_EN
                if (shuffle) begin
                    // shuffled order has no "last index"; count tracks instead
                    if (int'(played) + 1 >= NUM_SONGS) begin
                        auto_end = 1'b1;
                        auto_sel = '0;
                    end
                end else if (song_sel == LAST) begin
                    auto_end = 1'b1;
                    auto_sel = '0;
                end
`else
                if (song_sel == LAST) begin
                    auto_end = 1'b1;
                    auto_sel = '0;
                end
`endif
            end
            default: ;  // REP_ALL and 2'b11
        endcase
    end

    // next-state logic; priority stop > next > prev > fin_edge
    always_comb begin
        nxt_state  = state;
        nxt_sel    = song_sel;
        nxt_gap    = gap_cnt;
        nxt_pend   = pend_end;
        nxt_at_end = at_end;
`ifdef SEQ_SHUFFLE_EN
        nxt_played = played;
`endif
        case (state)
            STOPPED: begin
                if (stop) begin
                    nxt_state = STOPPED;
                end else if (next) begin
                    nxt_sel = fwd_sel;
                end else if (prev) begin
                    nxt_sel = dec_idx(song_sel);
                end else if (start) begin
                    nxt_state  = LOAD;
                    nxt_at_end = 1'b0;
`ifdef SEQ_SHUFFLE_EN
                    nxt_played = '0;
`endif
                end
            end
            LOAD: nxt_state = PLAY;
            PLAY: begin
                if (stop) begin
                    nxt_state = STOPPED;
                end else if (next) begin
                    nxt_state = LOAD;
                    nxt_sel   = fwd_sel;
                end else if (prev) begin
                    nxt_state = LOAD;
                    nxt_sel   = dec_idx(song_sel);
                end else if (fin_edge) begin
                    nxt_state = GAP;
                    nxt_gap   = GAP_LOAD;
                    nxt_sel   = auto_sel;
                    nxt_pend  = auto_end;
`ifdef SEQ_SHUFFLE_EN
                    if (int'(played) < NUM_SONGS) nxt_played = played + 1'b1;
`endif
                end
            end
            GAP: begin
                if (stop) begin
                    nxt_state = STOPPED;
                    nxt_pend  = 1'b0;
                end else if (next) begin
                    nxt_state = LOAD;
                    nxt_sel   = fwd_sel;
                    nxt_pend  = 1'b0;
                end else if (prev) begin
                    nxt_state = LOAD;
                    nxt_sel   = dec_idx(song_sel);
                    nxt_pend  = 1'b0;
                end else if (gap_cnt == '0) begin
                    nxt_pend = 1'b0;
                    if (pend_end) begin
                        nxt_state  = STOPPED;
                        nxt_at_end = 1'b1;
                    end else begin
                        nxt_state = LOAD;
                    end
                end else begin
                    nxt_gap = gap_cnt - 32'd1;
                end
            end
            default: nxt_state = STOPPED;
        endcase
    end

    // state and datapath registers; finished_d resets high so a level
    // already present at reset is not taken as an end-of-track edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= STOPPED;
            song_sel   <= '0;
            gap_cnt    <= '0;
            pend_end   <= 1'b0;
            at_end     <= 1'b0;
            finished_d <= 1'b1;
        end else begin
            state      <= nxt_state;
            song_sel   <= nxt_sel;
            gap_cnt    <= nxt_gap;
            pend_end   <= nxt_pend;
            at_end     <= nxt_at_end;
            finished_d <= song_finished;
        end
    end

`ifdef SEQ_SHUFFLE_EN
    // tracks played since start, for shuffled repeat-none
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) played <= '0;
        else        played <= nxt_played;
    end
`endif

endmodule
